// File: rtl/hydro_sample_axil_fifo.sv
// ---------------------------------------------------------------------------
// hydro_sample_axil_fifo
//
// AXI4-Lite slave that buffers hydrophone ADC samples in an internal FIFO and
// makes them readable by the PS through four word-aligned registers:
//   0x0 CTRL   : bit0 enable, bit1 clear (self-clearing, reads 0), bit2 irq_en
//   0x4 STATUS : [N:0] count, 16 empty, 17 full, 18 overflow (W1C),
//                19 underflow (W1C)
//   0x8 DATA   : read pops one entry; read while empty returns 0 and sets
//                underflow; writes are ignored
//   0xC THRESH : [N:0] level at or above which irq asserts (0 disables)
//
// Optional feature macro: HYDRO_FIFO_TIMESTAMP_EN
//   When defined, each entry also stores a 16-bit free-running sample index
//   and DATA returns {index, zero-padded sample}. When undefined, entries hold
//   the sample only and DATA returns it sign-extended to 32 bits.
//
// Ports:
//   ACLK, ARESETN         : clock, asynchronous active-low reset
//   sample_valid/_data    : one-cycle qualified signed ADC sample stream
//   S_AXI_AW*/W*/B*       : AXI4-Lite write address/data/response channels
//   S_AXI_AR*/R*          : AXI4-Lite read address/data channels
//   irq                   : registered level interrupt
// ---------------------------------------------------------------------------
module hydro_sample_axil_fifo #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int SAMPLE_WIDTH       = 16,
   parameter int FIFO_DEPTH_LOG2    = 5
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic                              sample_valid,
   input  logic [SAMPLE_WIDTH-1:0]           sample_data,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic                              irq
);

   localparam int DW    = C_S_AXI_DATA_WIDTH;
   localparam int BW    = C_S_AXI_DATA_WIDTH / 8;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef HYDRO_FIFO_TIMESTAMP_EN
   localparam int EW = 16 + SAMPLE_WIDTH;
`else
   localparam int EW = SAMPLE_WIDTH;
`endif

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DATA   = 2'd2;
   localparam logic [1:0] REG_THRESH = 2'd3;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_word,
                                                input logic [DW-1:0] new_word,
                                                input logic [BW-1:0] strb);
      logic [DW-1:0] r;
      r = old_word;
      for (int b = 0; b < BW; b++) begin
         if (strb[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return r;
   endfunction

`ifdef HYDRO_FIFO_TIMESTAMP_EN
   function automatic logic [15:0] zero_pad(input logic [SAMPLE_WIDTH-1:0] s);
      return 16'(s);
   endfunction
`else
   function automatic logic [DW-1:0] sign_ext(input logic [SAMPLE_WIDTH-1:0] s);
      logic signed [SAMPLE_WIDTH-1:0] v;
      v = signed'(s);
      return DW'(v);
   endfunction
`endif

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   typedef enum logic { W_IDLE, W_RESP } wstate_t;
   typedef enum logic { R_IDLE, R_DATA } rstate_t;

   wstate_t wstate, wstate_next;
   rstate_t rstate, rstate_next;
   logic    aw_accept, ar_accept;

   logic                       enable, irq_en, clear_pend;
   logic [CW-1:0]              thresh;
   logic [CW-1:0]              count;
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic                       overflow, underflow;
   logic                       empty, full;
   logic [EW-1:0]              mem [DEPTH];
   logic [EW-1:0]              entry_in, head;
   logic [DW-1:0]              head_word;
   logic [DW-1:0]              ctrl_merged, thresh_merged, rdata_next;
   logic [1:0]                 wsel, rsel;
   logic                       push_req, push_ok, pop;
   logic                       overflow_set, underflow_set, w1c_ovf, w1c_udf;
   logic                       unused;

   assign wsel = S_AXI_AWADDR[3:2];
   assign rsel = S_AXI_ARADDR[3:2];

   // ------------------------------------------------------------------------
   // AXI write FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) wstate <= W_IDLE;
      else          wstate <= wstate_next;
   end

   always_comb begin
      wstate_next  = wstate;
      aw_accept    = 1'b0;
      S_AXI_BVALID = 1'b0;
      case (wstate)
         W_IDLE: begin
            // Address and data must both be present; either alone waits.
            if (S_AXI_AWVALID && S_AXI_WVALID && ARESETN) begin
               aw_accept   = 1'b1;
               wstate_next = W_RESP;
            end
         end
         W_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) wstate_next = W_IDLE;
         end
         default: wstate_next = W_IDLE;
      endcase
   end

   assign S_AXI_AWREADY = aw_accept;
   assign S_AXI_WREADY  = aw_accept;
   assign S_AXI_BRESP   = 2'b00;

   // ------------------------------------------------------------------------
   // AXI read FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) rstate <= R_IDLE;
      else          rstate <= rstate_next;
   end

   always_comb begin
      rstate_next  = rstate;
      ar_accept    = 1'b0;
      S_AXI_RVALID = 1'b0;
      case (rstate)
         R_IDLE: begin
            if (S_AXI_ARVALID && ARESETN) begin
               ar_accept   = 1'b1;
               rstate_next = R_DATA;
            end
         end
         R_DATA: begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY) rstate_next = R_IDLE;
         end
         default: rstate_next = R_IDLE;
      endcase
   end

   assign S_AXI_ARREADY = ar_accept;
   assign S_AXI_RRESP   = 2'b00;

   // ------------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------------
   assign ctrl_merged   = merge_strb(DW'({irq_en, 1'b0, enable}), S_AXI_WDATA, S_AXI_WSTRB);
   assign thresh_merged = merge_strb(DW'(thresh), S_AXI_WDATA, S_AXI_WSTRB);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         enable     <= 1'b0;
         irq_en     <= 1'b0;
         thresh     <= '0;
         clear_pend <= 1'b0;
      end else begin
         clear_pend <= 1'b0;
         if (aw_accept) begin
            case (wsel)
               REG_CTRL: begin
                  enable     <= ctrl_merged[0];
                  irq_en     <= ctrl_merged[2];
                  // Clear is a one-cycle pulse acting on the FIFO next cycle.
                  clear_pend <= ctrl_merged[1];
               end
               REG_THRESH: thresh <= thresh_merged[CW-1:0];
               default: ;
            endcase
         end
      end
   end

   assign w1c_ovf = aw_accept && (wsel == REG_STATUS) && S_AXI_WSTRB[2] && S_AXI_WDATA[18];
   assign w1c_udf = aw_accept && (wsel == REG_STATUS) && S_AXI_WSTRB[2] && S_AXI_WDATA[19];

   // ------------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------------
   assign empty         = (count == '0);
   assign full          = (count == FULL_CNT);
   assign push_req      = sample_valid && enable;
   assign pop           = ar_accept && (rsel == REG_DATA) && !empty;
   assign underflow_set = ar_accept && (rsel == REG_DATA) && empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // still succeeds then.
   assign push_ok       = push_req && (!full || pop);
   assign overflow_set  = push_req && full && !pop;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear_pend) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         // A new event wins over a simultaneous software clear.
         if (overflow_set)  overflow  <= 1'b1;
         else if (w1c_ovf)  overflow  <= 1'b0;
         if (underflow_set) underflow <= 1'b1;
         else if (w1c_udf)  underflow <= 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (push_ok && !clear_pend) mem[wr_ptr] <= entry_in;
   end

   assign head = mem[rd_ptr];

`ifdef HYDRO_FIFO_TIMESTAMP_EN
   logic [15:0] sample_idx;

   // Counts every push attempt while enabled, including dropped ones.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)        sample_idx <= '0;
      else if (clear_pend) sample_idx <= '0;
      else if (push_req)   sample_idx <= sample_idx + 16'd1;
   end

   assign entry_in  = {sample_idx, sample_data};
   assign head_word = DW'({head[EW-1 -: 16], zero_pad(head[SAMPLE_WIDTH-1:0])});
`else
   assign entry_in  = sample_data;
   assign head_word = sign_ext(head);
`endif

   // ------------------------------------------------------------------------
   // Read data mux and response register
   // ------------------------------------------------------------------------
   always_comb begin
      rdata_next = '0;
      case (rsel)
         REG_CTRL:   rdata_next = DW'({irq_en, 1'b0, enable});
         REG_STATUS: begin
            rdata_next[CW-1:0] = count;
            rdata_next[16]     = empty;
            rdata_next[17]     = full;
            rdata_next[18]     = overflow;
            rdata_next[19]     = underflow;
         end
         REG_DATA:   if (!empty) rdata_next = head_word;
         REG_THRESH: rdata_next = DW'(thresh);
         default: ;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)       S_AXI_RDATA <= '0;
      else if (ar_accept) S_AXI_RDATA <= rdata_next;
   end

   // ------------------------------------------------------------------------
   // Interrupt (one cycle behind count)
   // ------------------------------------------------------------------------
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) irq <= 1'b0;
      else          irq <= irq_en && (thresh != '0) && (count >= thresh);
   end

   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                     ctrl_merged, thresh_merged};

endmodule

// File: tb/tb_hydro_sample_axil_fifo.sv
module tb_hydro_sample_axil_fifo;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_data = '0;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        irq;

   always #5 clk = ~clk;

   hydro_sample_axil_fifo dut (
      .ACLK(clk), .ARESETN(rst_n),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .irq(irq)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: the queue holds the word a DATA read must return.
   logic [31:0] q[$];
   logic        m_en, m_irqen, m_ovf, m_udf;
   logic [5:0]  m_thr;
   logic [15:0] m_idx;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_en = 0; m_irqen = 0; m_ovf = 0; m_udf = 0; m_thr = '0; m_idx = '0;
   endfunction

   function automatic logic [31:0] exp_word(input logic [15:0] s);
`ifdef HYDRO_FIFO_TIMESTAMP_EN
      return {m_idx, s};
`else
      return {{16{s[15]}}, s};
`endif
   endfunction

   function automatic void model_push(input logic [15:0] s);
      if (m_en) begin
         if (q.size() == DEPTH) m_ovf = 1'b1;
         else                   q.push_back(exp_word(s));
         m_idx = m_idx + 16'd1;
      end
   endfunction

   function automatic logic [31:0] model_status();
      logic [31:0] w;
      w = '0;
      w[5:0] = 6'(q.size());
      w[16]  = (q.size() == 0);
      w[17]  = (q.size() == DEPTH);
      w[18]  = m_ovf;
      w[19]  = m_udf;
      return w;
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a[3:2])
         2'd0: return {29'd0, m_irqen, 1'b0, m_en};
         2'd1: return model_status();
         2'd2: begin
            if (q.size() == 0) begin
               m_udf = 1'b1;
               return 32'd0;
            end
            return q.pop_front();
         end
         default: return {26'd0, m_thr};
      endcase
   endfunction

   function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      case (a[3:2])
         2'd0: if (s[0]) begin
            m_en    = d[0];
            m_irqen = d[2];
            if (d[1]) begin
               q.delete(); m_ovf = 0; m_udf = 0; m_idx = '0;
            end
         end
         2'd1: if (s[2]) begin
            if (d[18]) m_ovf = 1'b0;
            if (d[19]) m_udf = 1'b0;
         end
         2'd3: if (s[0]) m_thr = d[5:0];
         default: ;
      endcase
   endfunction

   function automatic logic model_irq();
      return m_irqen && (m_thr != 0) && (q.size() >= int'(m_thr));
   endfunction

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      n = 0;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      #1;
      while (!(awready && wready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check_eq("awready", 32'(awready && wready), 32'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check_eq("bvalid", 32'(bvalid), 32'd1);
      check_eq("bresp", 32'(bresp), 32'd0);
      model_write(a, d, s);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check_eq("bvalid_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      #1;
      while (!arready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check_eq("arready", 32'(arready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      check_eq("rvalid", 32'(rvalid), 32'd1);
      check_eq("rresp", 32'(rresp), 32'd0);
      d = rdata;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] a);
      logic [31:0] got, exp;
      axi_read(a, got);
      exp = model_read(a);
      check_eq(tag, got, exp);
   endtask

   task automatic push(input logic [15:0] s);
      @(negedge clk);
      sample_valid = 1'b1; sample_data = s;
      @(negedge clk);
      sample_valid = 1'b0;
      model_push(s);
   endtask

   task automatic check_irq(input string tag);
      @(negedge clk);
      check_eq(tag, 32'(irq), 32'(model_irq()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got, exp, first;
      logic        stable;

      // Reset
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_bvalid", 32'(bvalid), 32'd0);
      check_eq("rst_rvalid", 32'(rvalid), 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      read_check("rst_status", 4'h4);
      read_check("rst_ctrl", 4'h0);
      read_check("rst_thresh", 4'hC);

      // 1. Basic capture
      axi_write(4'h0, 32'h1, 4'hF);
      for (int i = 1; i <= 4; i++) push(16'(i));
      read_check("t1_status4", 4'h4);
      for (int i = 0; i < 4; i++) read_check("t1_data", 4'h8);
      read_check("t1_empty", 4'h4);

      // 2. Overflow
      axi_write(4'h0, 32'h3, 4'hF);
      for (int i = 0; i < 33; i++) push(16'(16'h0100 + i));
      read_check("t2_full_ovf", 4'h4);
      axi_write(4'h4, 32'h0004_0000, 4'hF);
      read_check("t2_w1c", 4'h4);
      for (int i = 0; i < 32; i++) read_check("t2_data", 4'h8);
      read_check("t2_empty", 4'h4);

      // 3. Underflow and sign extension
      read_check("t3_empty_data", 4'h8);
      read_check("t3_udf", 4'h4);
      axi_write(4'h4, 32'h0008_0000, 4'h4);
      push(16'h8000);
      read_check("t3_signext", 4'h8);
      read_check("t3_status", 4'h4);

      // 4. Interrupt timing
      axi_write(4'hC, 32'd3, 4'hF);
      axi_write(4'h0, 32'h5, 4'hF);
      push(16'h0011);
      push(16'h0022);
      @(negedge clk);
      sample_valid = 1'b1; sample_data = 16'h0033;
      @(negedge clk);
      sample_valid = 1'b0;
      model_push(16'h0033);
      check_eq("t4_irq_lag", 32'(irq), 32'd0);
      @(negedge clk);
      check_eq("t4_irq_rise", 32'(irq), 32'd1);
      @(negedge clk);
      araddr = 4'h8; arvalid = 1'b1;
      #1 check_eq("t4_arready", 32'(arready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      check_eq("t4_irq_hold", 32'(irq), 32'd1);
      exp = model_read(4'h8);
      check_eq("t4_data", rdata, exp);
      @(negedge clk);
      check_eq("t4_irq_fall", 32'(irq), 32'd0);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;

      // 5. Handshake stalls
      @(negedge clk);
      awaddr = 4'hC; wdata = 32'd7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(4'hC, 32'd7, 4'hF);
      stable = 1'b1;
      repeat (10) begin
         stable &= bvalid;
         @(negedge clk);
      end
      check_eq("t5_bvalid_hold", 32'(stable), 32'd1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check_eq("t5_bvalid_drop", 32'(bvalid), 32'd0);

      @(negedge clk);
      araddr = 4'hC; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      first = rdata;
      check_eq("t5_rdata", first, model_read(4'hC));
      stable = 1'b1;
      repeat (10) begin
         stable &= rvalid && (rdata == first);
         arvalid = 1'b1; araddr = 4'h0;
         @(negedge clk);
      end
      arvalid = 1'b0;
      check_eq("t5_rvalid_hold", 32'(stable), 32'd1);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;

      @(negedge clk);
      awaddr = 4'h0; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b0;
      stable = 1'b0;
      repeat (5) begin
         #1 stable |= awready;
         @(negedge clk);
      end
      awvalid = 1'b0;
      check_eq("t5_aw_alone", 32'(stable), 32'd0);
      read_check("t5_ctrl_kept", 4'h0);

      axi_write(4'h0, 32'h3, 4'hF);
      for (int i = 0; i < DEPTH; i++) push(16'(16'h0200 + i));
      @(negedge clk);
      araddr = 4'h8; arvalid = 1'b1; sample_valid = 1'b1; sample_data = 16'hABCD;
      @(negedge clk);
      arvalid = 1'b0; sample_valid = 1'b0;
      exp = model_read(4'h8);
      model_push(16'hABCD);
      check_eq("t5_pushpop_data", rdata, exp);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      read_check("t5_pushpop_count", 4'h4);

      // 6. Reset in the middle of a read
      axi_write(4'hC, 32'd3, 4'hF);
      axi_write(4'h0, 32'h5, 4'hF);
      check_irq("t6_irq_before");
      @(negedge clk);
      araddr = 4'h8; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      check_eq("t6_rvalid_pre", 32'(rvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_rvalid_async", 32'(rvalid), 32'd0);
      check_eq("t6_irq_async", 32'(irq), 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      read_check("t6_status", 4'h4);
      read_check("t6_ctrl", 4'h0);
      read_check("t6_thresh", 4'hC);

      // 7. Randomized traffic against the model
      axi_write(4'h0, 32'h1, 4'hF);
      for (int it = 0; it < 300; it++) begin
         int op;
         logic [31:0] d;
         logic [3:0]  a;
         op = int'($urandom_range(0, 9));
         case (op)
            0, 1, 2, 3: begin
               int k;
               k = int'($urandom_range(1, 8));
               for (int j = 0; j < k; j++) push(16'($urandom));
            end
            4, 5: read_check("rnd_data", 4'h8);
            6: begin
               a = {2'($urandom_range(0, 3)), 2'b00};
               read_check("rnd_reg", a);
            end
            7: begin
               d = $urandom;
               d[0] = ($urandom_range(0, 3) != 0);
               d[1] = ($urandom_range(0, 7) == 0);
               axi_write(4'h0, d, ($urandom_range(0, 3) != 0) ? 4'hF : 4'(($urandom)));
            end
            8: begin
               d = $urandom;
               a = ($urandom_range(0, 4) == 0) ? 4'h8 : 4'hC;
               axi_write(a, d, 4'($urandom));
            end
            default: begin
               d = '0;
               d[18] = 1'($urandom);
               d[19] = 1'($urandom);
               axi_write(4'h4, d, 4'($urandom));
            end
         endcase
         check_irq("rnd_irq");
      end
      read_check("rnd_final_status", 4'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hydro_sample_axil_fifo.md
# hydro_sample_axil_fifo

AXI4-Lite slave that buffers hydrophone ADC samples in an internal FIFO and exposes them through four word-aligned registers to the PS over the `audio_connect` AXI4-Lite path. The block sits downstream of the sample capture logic and upstream of the AXI interconnect/master. It turns a free-running `sample_valid` stream into software-readable data and provides a level-threshold interrupt.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: AXI data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 4: AXI address width; `addr[3:2]` selects the register.
- `SAMPLE_WIDTH`, 16: ADC sample width, 1–16.
- `FIFO_DEPTH_LOG2`, 5: FIFO depth is 2^N entries (32 by default).

Ports (name, direction, width, meaning):
- `ACLK` in 1: single clock for the whole block.
- `ARESETN` in 1: reset, asynchronous assert, active-low.
- `sample_valid` in 1: one-cycle qualifier for `sample_data`.
- `sample_data` in SAMPLE_WIDTH: signed ADC sample.
- `S_AXI_AWADDR` in ADDR_W; `S_AXI_AWPROT` in 3 (ignored); `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in ADDR_W; `S_AXI_ARPROT` in 3 (ignored); `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1.
- `irq` out 1: level interrupt.

## Operation

**Register map**
- 0x0 CTRL (R/W)
  - bit0 `enable`
  - bit1 `clear`: self-clearing, always reads 0
  - bit2 `irq_en`
  - other bits read 0
- 0x4 STATUS (RO, except W1C bits)
  - [FIFO_DEPTH_LOG2:0] `count`
  - bit16 `empty`
  - bit17 `full`
  - bit18 `overflow` (sticky, W1C)
  - bit19 `underflow` (sticky, W1C)
- 0x8 DATA (RO)
  - A read pops one entry and returns `sample` sign-extended to 32 bits.
  - A read while empty returns 0, does not pop, and sets `underflow`.
  - Writes to DATA are ignored.
- 0xC THRESH (R/W, [FIFO_DEPTH_LOG2:0])
  - `irq` = `irq_en & (THRESH != 0) & (count >= THRESH)`.

**Write path**
- `WSTRB` byte enables apply to CTRL and THRESH.
- W1C on STATUS uses byte 2.
- `clear` resets the FIFO pointers, `count`, `overflow` and `underflow` in the cycle after the write is accepted. CTRL and THRESH are unchanged.

**FIFO**
- Push when `sample_valid & enable`.
- Push when full: the sample is dropped and `overflow` is set.
- Pop occurs on the cycle the DATA read address is accepted.
- Simultaneous push and pop (including when full): both take effect and `count` is unchanged.
- A `clear` in the same cycle as a push wins; the sample is discarded.
- Pointers wrap modulo 2^N. `count` is N+1 bits.

**AXI write FSM** (W_IDLE → W_RESP)
- In W_IDLE, when `AWVALID & WVALID`, assert `AWREADY` and `WREADY` for one cycle and latch the address and data.
- Then assert `BVALID` with `BRESP`=00 and hold it until `BREADY`, then return to W_IDLE.
- AW or W arriving alone waits in W_IDLE.

**AXI read FSM** (R_IDLE → R_DATA)
- In R_IDLE, when `ARVALID`, assert `ARREADY` for one cycle.
- `RDATA` is registered at that same edge and `RVALID` rises the next cycle with `RRESP`=00.
- `RVALID` and `RDATA` are held stable until `RREADY`.
- No new AR is accepted while `RVALID` is high.

## Timing
- Reset values:
  - All AXI ready/valid outputs 0; `RDATA`=0; `BRESP`=`RRESP`=00.
  - `irq`=0; CTRL=0; THRESH=0.
  - FIFO empty; sticky bits 0.
- Write latency: AW/W accepted on cycle T; register updated and `BVALID` high at T+1.
- Read latency: AR accepted on cycle T; `RVALID` high at T+1.
- Push on cycle T is visible in `count` to a STATUS read whose AR is accepted at T+1 or later.
- `irq` is registered and reflects `count` with one cycle of lag.
- Reset asserted mid-transaction: all FSMs return to idle immediately, outstanding BVALID/RVALID drop, and FIFO contents are lost. There is no response to a transaction that was in flight.

## Configuration
- `HYDRO_FIFO_TIMESTAMP_EN` defined:
  - A 16-bit free-running sample index increments on every push attempt while enabled (including dropped pushes), wrapping at 0xFFFF.
  - Each FIFO entry stores {index, sample}.
  - A DATA read returns index in [31:16] and the zero-padded sample in [15:0].
  - `clear` zeroes the index.
- Not defined:
  - No index storage; entries are SAMPLE_WIDTH bits.
  - DATA returns the sign-extended sample.

## Test plan
1. **Basic capture:** reset, write CTRL=0x1, push 0x0001..0x0004.
   - STATUS read gives `count`=4.
   - Four DATA reads return 1, 2, 3, 4.
   - Final STATUS has `empty`=1.
2. **Overflow:** `enable`=1, push 33 samples with no reads.
   - STATUS shows `count`=32, `full`=1, `overflow`=1.
   - The 33rd sample is absent from the read-back.
   - W1C write of 0x00040000 to STATUS clears `overflow`.
3. **Underflow and sign extension:** read DATA while empty.
   - Returns 0 and sets `underflow`.
   - Push 0x8000, then DATA read returns 0xFFFF8000 (macro off).
4. **Interrupt:** THRESH=3, CTRL=0x5, push 3 samples.
   - `irq` rises 1 cycle after `count` reaches 3.
   - One DATA read drops `irq` one cycle after the pop.
5. **Handshake:** hold `BREADY`/`RREADY` low for 10 cycles.
   - `BVALID`/`RVALID` and `RDATA` stay stable.
   - AW alone with no W gets no `AWREADY`.
   - Simultaneous push and pop at `count`=32 leaves `count`=32.
6. **Reset:** assert `ARESETN` low mid-read.
   - `RVALID`=0 immediately; FIFO empty, CTRL=0, `irq`=0.
